// File: rtl/snn_event_reader.sv
// Pops neuron addresses from the SNN output spike FIFO and counts spikes per neuron over a fixed window.
// At window end the counters are scanned and the most active neuron is reported.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; previous results and counters held
// COLLECT | window timer running, popping and counting FIFO events
// DRAIN   | one cycle so a pop from the last COLLECT cycle is captured
// SCAN    | one counter per cycle, running max (ties to lowest index)
// DONE    | results valid, done pulses, back to IDLE
module snn_event_reader #(
  parameter int NUM_NEURONS   = 16,
  parameter int ADDR_W        = 4,
  parameter int CNT_W         = 8,
  parameter int WINDOW_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              snn_event_n,
  input  logic [ADDR_W-1:0] neuron_addr_in,
  output logic              snn_ren,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] winner_addr,
  output logic [CNT_W-1:0]  winner_count,
  output logic              winner_valid,
  output logic [15:0]       total_events,
  input  logic [ADDR_W-1:0] count_rd_addr,
  output logic [CNT_W-1:0]  count_rd_data
);

  localparam int TIMER_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 2;

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, SCAN, DONE} state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer;
  logic                timer_tc;
  logic                cap_valid;
  logic                addr_ok;
  logic                ren_nxt;
  logic [CNT_W-1:0]    cnt [NUM_NEURONS];
  logic [ADDR_W-1:0]   scan_idx;
  logic                scan_last;
  logic [CNT_W-1:0]    scan_cur;
  logic                scan_gt;
  logic [CNT_W-1:0]    max_cnt;
  logic [ADDR_W-1:0]   max_addr;
  logic                start_acc;

  assign timer_tc  = (timer == TIMER_W'(WINDOW_CYCLES - 1));
  assign scan_last = (scan_idx == ADDR_W'(NUM_NEURONS - 1));
  assign scan_cur  = cnt[scan_idx];
  assign scan_gt   = (scan_cur > max_cnt);
  assign start_acc = (state == IDLE) && start;

  // Addresses beyond the neuron count can only occur when the address space is not full.
  if (NUM_NEURONS == (1 << ADDR_W)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = ({1'b0, neuron_addr_in} < (ADDR_W + 1)'(NUM_NEURONS));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (timer_tc) state_nxt = DRAIN;
      DRAIN:   state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // At most one pop every other cycle, so the FIFO empty flag is current at each decision.
  assign ren_nxt = (state == COLLECT) && !timer_tc && !snn_event_n && !snn_ren;

  assign busy          = (state == COLLECT) || (state == DRAIN) || (state == SCAN);
  assign done          = (state == DONE);
  assign count_rd_data = cnt[count_rd_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      snn_ren   <= 1'b0;
      cap_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      snn_ren   <= ren_nxt;
      cap_valid <= snn_ren;
      if (start_acc) timer <= '0;
      else if (state == COLLECT) timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
      total_events <= '0;
    end else if (start_acc) begin
      for (int i = 0; i < NUM_NEURONS; i++) cnt[i] <= '0;
      total_events <= '0;
    end else if (cap_valid && addr_ok) begin
      if (cnt[neuron_addr_in] != {CNT_W{1'b1}}) cnt[neuron_addr_in] <= cnt[neuron_addr_in] + 1'b1;
      if (total_events != 16'hFFFF) total_events <= total_events + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_idx     <= '0;
      max_cnt      <= '0;
      max_addr     <= '0;
      winner_addr  <= '0;
      winner_count <= '0;
      winner_valid <= 1'b0;
    end else if (state == DRAIN) begin
      scan_idx <= '0;
      max_cnt  <= '0;
      max_addr <= '0;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
      if (scan_gt) begin
        max_cnt  <= scan_cur;
        max_addr <= scan_idx;
      end
      if (scan_last) begin
        winner_addr  <= scan_gt ? scan_idx : max_addr;
        winner_count <= scan_gt ? scan_cur : max_cnt;
        winner_valid <= (total_events != 16'd0);
      end
    end
  end

endmodule

// File: tb/tb_snn_event_reader.sv
// Scoreboard bench for snn_event_reader: a FIFO model feeds directed address lists,
// expected window results are queued at start and checked by a monitor on each done pulse.
module tb_snn_event_reader;

  localparam int NN  = 16;
  localparam int AW  = 4;
  localparam int CW  = 4;
  localparam int WC  = 64;
  localparam int LAT = 1 + WC + 1 + NN + 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          snn_event_n = 1'b1;
  logic [AW-1:0] neuron_addr_in = '0;
  logic          snn_ren;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [AW-1:0] winner_addr;
  logic [CW-1:0] winner_count;
  logic          winner_valid;
  logic [15:0]   total_events;
  logic [AW-1:0] count_rd_addr = '0;
  logic [CW-1:0] count_rd_data;

  snn_event_reader #(.NUM_NEURONS(NN), .ADDR_W(AW), .CNT_W(CW), .WINDOW_CYCLES(WC)) dut (
    .clock(clock), .reset_n(reset_n), .snn_event_n(snn_event_n), .neuron_addr_in(neuron_addr_in),
    .snn_ren(snn_ren), .start(start), .busy(busy), .done(done), .winner_addr(winner_addr),
    .winner_count(winner_count), .winner_valid(winner_valid), .total_events(total_events),
    .count_rd_addr(count_rd_addr), .count_rd_data(count_rd_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] waddr;
    logic [CW-1:0] wcnt;
    logic          wvalid;
    logic [15:0]   total;
    logic [CW-1:0] rd_data;
    int            start_cyc;
  } exp_t;

  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  int            pops = 0;
  int            done_seen = 0;
  logic          prev_ren = 1'b0;
  logic [AW-1:0] fifo_q[$];
  exp_t          sb_q[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // FIFO model: data for a pop appears within the cycle snn_ren is high and holds until the next pop.
  always @(negedge clock) begin
    if (snn_ren) begin
      chk("ren_back_to_back", {31'd0, prev_ren}, 32'd0);
      if (fifo_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fifo_underflow: got pop on empty FIFO, required no pop (cycle %0d)", cyc);
      end else begin
        neuron_addr_in = fifo_q.pop_front();
        pops++;
      end
    end
    prev_ren    = snn_ren;
    snn_event_n = (fifo_q.size() == 0);
  end

  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done pulse, required none (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("winner_addr",   32'(winner_addr),   32'(e.waddr));
        chk("winner_count",  32'(winner_count),  32'(e.wcnt));
        chk("winner_valid",  32'(winner_valid),  32'(e.wvalid));
        chk("total_events",  32'(total_events),  32'(e.total));
        chk("count_rd_data", 32'(count_rd_data), 32'(e.rd_data));
        chk("busy_at_done",  32'(busy),          32'd0);
        chk("latency",       32'(cyc - e.start_cyc + 1), 32'(LAT));
      end
    end
  end

  task automatic push(input logic [AW-1:0] a);
    fifo_q.push_back(a);
    snn_event_n = 1'b0;
  endtask

  task automatic run_window(input logic [AW-1:0] wa, input logic [CW-1:0] wc, input logic wv,
                            input int tot, input logic [AW-1:0] ra, input logic [CW-1:0] rd,
                            input bit extra_starts);
    exp_t e;
    int t;
    @(negedge clock);
    count_rd_addr = ra;
    e.waddr = wa; e.wcnt = wc; e.wvalid = wv; e.total = 16'(tot); e.rd_data = rd;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    t = 0;
    while (!done && t < LAT + 20) begin
      @(negedge clock);
      t++;
      start = extra_starts && (t == 10 || t == WC + 5);
    end
    start = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", t);
      sb_q.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int pops0;
    int done0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Idle with a non-empty FIFO: nothing is popped, all outputs at reset values
    push(3); push(3); push(5); push(3);
    repeat (10) @(negedge clock);
    chk("idle_pops",         32'(pops),          32'd0);
    chk("idle_snn_ren",      32'(snn_ren),       32'd0);
    chk("idle_busy",         32'(busy),          32'd0);
    chk("idle_done",         32'(done),          32'd0);
    chk("idle_winner_valid", 32'(winner_valid),  32'd0);
    chk("idle_total",        32'(total_events),  32'd0);
    chk("idle_count",        32'(count_rd_data), 32'd0);

    run_window(4'd3, 4'd3, 1'b1, 4, 4'd5, 4'd1, 1'b0);
    count_rd_addr = 4'd3;
    #1 chk("count_held_3", 32'(count_rd_data), 32'd3);

    // Tie resolves to the lower index, then an empty window
    push(9); push(2); push(9); push(2);
    run_window(4'd2, 4'd2, 1'b1, 4, 4'd9, 4'd2, 1'b0);
    run_window(4'd0, 4'd0, 1'b0, 0, 4'd2, 4'd0, 1'b0);

    // FIFO never empty: 32 pops in 64 cycles, the last (addr 15) issued on the final COLLECT cycle
    for (int i = 0; i < 40; i++) push(AW'(i % 16));
    pops0 = pops;
    run_window(4'd0, 4'd2, 1'b1, 32, 4'd15, 4'd2, 1'b0);
    chk("full_window_pops", 32'(pops - pops0), 32'd32);

    // Leftover events 0..7 are consumed by the next window
    run_window(4'd0, 4'd1, 1'b1, 8, 4'd7, 4'd1, 1'b0);
    chk("fifo_emptied", 32'(fifo_q.size()), 32'd0);

    // Saturation of a 4-bit counter, total keeps counting
    for (int i = 0; i < 20; i++) push(4'd7);
    run_window(4'd7, 4'd15, 1'b1, 20, 4'd7, 4'd15, 1'b0);

    // Reset mid-COLLECT abandons the window
    push(1); push(2); push(1); push(4);
    count_rd_addr = 4'd1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    chk("pre_reset_count", 32'(count_rd_data), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy",         32'(busy),          32'd0);
    chk("rst_snn_ren",      32'(snn_ren),       32'd0);
    chk("rst_total",        32'(total_events),  32'd0);
    chk("rst_count",        32'(count_rd_data), 32'd0);
    chk("rst_winner_addr",  32'(winner_addr),   32'd0);
    chk("rst_winner_count", 32'(winner_count),  32'd0);
    chk("rst_winner_valid", 32'(winner_valid),  32'd0);
    fifo_q.delete();
    snn_event_n = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;

    // New start accepted; extra start pulses in COLLECT and SCAN are ignored
    push(6); push(6);
    done0 = done_seen;
    run_window(4'd6, 4'd2, 1'b1, 2, 4'd6, 4'd2, 1'b1);
    repeat (LAT + 10) @(negedge clock);
    chk("single_done", 32'(done_seen - done0), 32'd1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snn_event_reader.md
Name: snn_event_reader

Overview:
- Consumer for the SNN core's output spike FIFO. It pops neuron addresses using the read-enable / active-low-event / address handshake and counts spikes per output neuron over a fixed time window.
- At the end of each window it scans the counters and reports the winning (most-spiking) neuron.
- Sits between the SNN core output and the host or classification logic.

Parameters:
- NUM_NEURONS, 16: number of output neurons and counters.
- ADDR_W, 4: neuron address width; must equal $clog2(NUM_NEURONS).
- CNT_W, 8: per-neuron counter width. Counters saturate.
- WINDOW_CYCLES, 1024: length of the collection window in clock cycles; minimum 4.

Ports:
- clock, input, 1: system clock; all logic is rising-edge.
- reset_n, input, 1: asynchronous, active-low reset.
- snn_event_n, input, 1: low when the SNN output FIFO is non-empty.
- neuron_addr_in, input, ADDR_W: FIFO read data; valid the cycle after snn_ren.
- snn_ren, output, 1: FIFO read enable (pop).
- start, input, 1: single-cycle pulse that begins a window.
- busy, output, 1: high from the start-accept cycle until done.
- done, output, 1: one-cycle pulse when results are valid.
- winner_addr, output, ADDR_W: address of the neuron with the highest count.
- winner_count, output, CNT_W: count of that neuron.
- winner_valid, output, 1: high if at least one event was counted in the window.
- total_events, output, 16: events counted this window; saturating.
- count_rd_addr, input, ADDR_W: address for per-neuron count readout.
- count_rd_data, output, CNT_W: combinational count of the neuron at count_rd_addr.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - All counters, timer, total_events, winner_addr, winner_count, winner_valid, snn_ren, busy and done are 0.
  - Reset mid-window abandons the window. Pending FIFO data is not captured.
- FSM states: IDLE, COLLECT, DRAIN, SCAN, DONE.
- IDLE:
  - snn_ren = 0.
  - start = 1 clears all counters, total_events and the timer in the same edge, sets busy and moves to COLLECT.
  - Previous winner outputs are held until the next SCAN writes them.
- COLLECT:
  - The timer increments every cycle. At timer == WINDOW_CYCLES-1 the FSM moves to DRAIN.
  - snn_ren is registered. It is driven to 1 for one cycle when snn_event_n == 0, snn_ren is currently 0, and the FSM is not leaving COLLECT.
  - This gives at most one pop per 2 cycles, so the FIFO's empty flag has always updated before the next pop decision. This guarantees no underflow.
- Capture:
  - The cycle after snn_ren == 1, sample neuron_addr_in.
  - counter[addr] += 1, saturating at 2^CNT_W-1.
  - total_events += 1, saturating at 65535.
  - Addresses >= NUM_NEURONS are dropped and not counted.
- DRAIN:
  - snn_ren = 0.
  - Lasts one cycle so a pop issued on the last COLLECT cycle is still captured. Then moves to SCAN.
- SCAN:
  - Index runs 0..NUM_NEURONS-1, one counter per cycle (NUM_NEURONS cycles).
  - Running max is updated only on strictly greater, so ties resolve to the lowest index.
  - After the last index, winner_addr and winner_count are written and winner_valid = (total_events != 0).
  - With all-zero counts: winner_addr = 0, winner_count = 0, winner_valid = 0.
- DONE:
  - done = 1 for exactly one cycle and busy drops to 0 in the same cycle. Next state is IDLE.
- start while busy is ignored.
- Latency: start to done = 1 + WINDOW_CYCLES + 1 + NUM_NEURONS + 1 cycles. The exact count is checked by the bench.
- count_rd_data is readable at any time; counters are held after done until the next start.
- Events still in the FIFO at window end stay in the FIFO and are consumed in the next window.

Test Plan:
1. Reset then idle, FIFO non-empty, no start -> snn_ren stays 0, all outputs 0.
2. WINDOW_CYCLES=64; FIFO model delivers addresses 3,3,5,3 -> done pulses once. winner_addr=3, winner_count=3, total_events=4, count_rd_data(5)=1.
3. Tie: addresses 9,2,9,2 -> winner_addr=2, winner_count=2, winner_valid=1. Empty window -> winner_valid=0, winner_addr=0.
4. FIFO continuously non-empty for the whole window -> snn_ren never high on consecutive cycles. Pops = captures = 32 for a 64-cycle window, and a pop on the last COLLECT cycle is counted.
5. CNT_W=4: 20 events to address 7 -> count_rd_data(7)=15 (saturated), total_events=20.
6. reset_n asserted mid-COLLECT -> immediate return to idle with all counters 0. Then start is accepted normally. start pulses during SCAN -> ignored, with a single done pulse.
